// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester Block_RAM port arbiter.
package ram_arb_pkg;

    localparam int NUM_REQ        = 2;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int STRB_W         = DEF_DATA_WIDTH / 8;

    // Requester indices; also the encoding of last_gnt and rd_owner.
    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // Byte-strobe width for an arbitrary data width.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic               clka,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_gnt_idx,
    output logic               o_gnt_any
);

    logic r_last_gnt;

    // Grant the sole requester, or the one that did not win last time.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        o_gnt = '0;
        if (!rst) begin
            if (i_req[REQ_M0] && (!i_req[REQ_M1] || (r_last_gnt == REQ_M1))) begin
                o_gnt[REQ_M0] = 1'b1;
            end else if (i_req[REQ_M1]) begin
                o_gnt[REQ_M1] = 1'b1;
            end
        end
    end

    assign o_gnt_idx = o_gnt[REQ_M1] ? REQ_M1 : REQ_M0;
    assign o_gnt_any = |o_gnt;

    // Remember the winner; idle cycles leave fairness untouched.
    always_ff @(posedge clka) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            r_last_gnt <= REQ_M1;
        end else if (o_gnt_any) begin
            r_last_gnt <= o_gnt_idx;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one Block_RAM between m0 (CPU data side) and m1 (DMA/accelerator):
// one access per cycle, round-robin, read data steered back to its issuer.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clka,
    input  logic                            rst,
    input  logic                            m0_req,
    input  logic [strb_width(DATA_WIDTH)-1:0] m0_we,
    input  logic [ADDR_WIDTH-1:0]           m0_addr,
    input  logic [DATA_WIDTH-1:0]           m0_wdata,
    output logic                            m0_gnt,
    output logic                            m0_rvalid,
    output logic [DATA_WIDTH-1:0]           m0_rdata,
    input  logic                            m1_req,
    input  logic [strb_width(DATA_WIDTH)-1:0] m1_we,
    input  logic [ADDR_WIDTH-1:0]           m1_addr,
    input  logic [DATA_WIDTH-1:0]           m1_wdata,
    output logic                            m1_gnt,
    output logic                            m1_rvalid,
    output logic [DATA_WIDTH-1:0]           m1_rdata,
    output logic [ADDR_WIDTH-1:0]           ram_addra,
    output logic [DATA_WIDTH-1:0]           ram_dina,
    output logic [strb_width(DATA_WIDTH)-1:0] ram_wea,
    output logic [ADDR_WIDTH-1:0]           ram_addrb,
    input  logic [DATA_WIDTH-1:0]           ram_doutb
);

    localparam int BE_W = strb_width(DATA_WIDTH);

    logic [NUM_REQ-1:0]    w_gnt;
    logic                  w_gnt_idx;
    logic                  w_gnt_any;
    logic [BE_W-1:0]       w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_is_wr;
    logic                  w_is_rd;
    logic                  r_rd_pend;
    logic                  r_rd_owner;

    rr_arbiter2 u_arb (
        .clka      (clka),
        .rst       (rst),
        .i_req     ({m1_req, m0_req}),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    assign m0_gnt = w_gnt[REQ_M0];
    assign m1_gnt = w_gnt[REQ_M1];

    // Select the winning requester's command.
    assign w_sel_we    = (w_gnt_idx == REQ_M1) ? m1_we    : m0_we;
    assign w_sel_addr  = (w_gnt_idx == REQ_M1) ? m1_addr  : m0_addr;
    assign w_sel_wdata = (w_gnt_idx == REQ_M1) ? m1_wdata : m0_wdata;

    // A grant is either a write (any strobe set) or a read, never both.
    assign w_is_wr = w_gnt_any && (w_sel_we != '0);
    assign w_is_rd = w_gnt_any && (w_sel_we == '0);

    // Drive the RAM ports; unused ports and idle cycles park at zero.
    always_comb begin
        ram_addra = '0;
        ram_dina  = '0;
        ram_wea   = '0;
        ram_addrb = '0;
        if (w_is_wr) begin
            ram_addra = w_sel_addr;
            ram_dina  = w_sel_wdata;
            ram_wea   = w_sel_we;
        end else if (w_is_rd) begin
            ram_addrb = w_sel_addr;
        end
    end

    // Track the one read in flight so its data returns to the issuer.
    always_ff @(posedge clka) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= REQ_M0;
        end else begin
            r_rd_pend  <= w_is_rd;
            r_rd_owner <= w_gnt_idx;
        end
    end

    assign m0_rvalid = r_rd_pend && (r_rd_owner == REQ_M0);
    assign m1_rvalid = r_rd_pend && (r_rd_owner == REQ_M1);
    assign m0_rdata  = m0_rvalid ? ram_doutb : '0;
    assign m1_rdata  = m1_rvalid ? ram_doutb : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: behavioural Block_RAM, reference memory and
// per-requester read scoreboards checked when rvalid appears.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clka = 1'b0;
    logic          rst  = 1'b1;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [SW-1:0] m0_we = '0, m1_we = '0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina;
    logic [SW-1:0] ram_wea;
    logic [DW-1:0] ram_doutb = '0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rd_exp_t;

    rd_exp_t       exp_q0[$];
    rd_exp_t       exp_q1[$];
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc_cnt = 0;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clka      (clka),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    always #5 clka = ~clka;

    always @(posedge clka) cyc_cnt++;

    // Behavioural Block_RAM: byte-write port A, registered read port B.
    always @(posedge clka) begin
        for (int b = 0; b < SW; b++) begin
            if (ram_wea[b]) ram_mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
        end
        ram_doutb <= ram_mem[ram_addrb];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [SW-1:0] we, input logic [DW-1:0] d);
        for (int b = 0; b < SW; b++) begin
            if (we[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Read-return monitor, sampled in the low clock phase.
    always @(negedge clka) begin
        rd_exp_t e;
        if (m0_rvalid) begin
            if (exp_q0.size() == 0) check("m0_rvalid_spurious", 1, 0);
            else begin
                e = exp_q0.pop_front();
                check("m0_rdata", m0_rdata, e.data);
                check("m0_rd_latency", cyc_cnt, e.cyc);
            end
        end else begin
            check("m0_rdata_gated", m0_rdata, 0);
        end
        if (m1_rvalid) begin
            if (exp_q1.size() == 0) check("m1_rvalid_spurious", 1, 0);
            else begin
                e = exp_q1.pop_front();
                check("m1_rdata", m1_rdata, e.data);
                check("m1_rd_latency", cyc_cnt, e.cyc);
            end
        end else begin
            check("m1_rdata_gated", m1_rdata, 0);
        end
    end

    // One cycle of stimulus with the expected grants; checks the RAM ports
    // and books the expected outcome of each granted access.
    task automatic step(
        input logic r0, input logic [SW-1:0] w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic r1, input logic [SW-1:0] w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic eg0, input logic eg1
    );
        logic [SW-1:0] e_wea;
        logic [AW-1:0] e_addra, e_addrb;
        logic [DW-1:0] e_dina;
        @(negedge clka);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        check("m0_gnt", m0_gnt, eg0);
        check("m1_gnt", m1_gnt, eg1);
        e_wea = '0; e_addra = '0; e_dina = '0; e_addrb = '0;
        if (eg0) begin
            if (w0 != 0) begin e_wea = w0; e_addra = a0; e_dina = d0; end
            else e_addrb = a0;
        end else if (eg1) begin
            if (w1 != 0) begin e_wea = w1; e_addra = a1; e_dina = d1; end
            else e_addrb = a1;
        end
        check("ram_wea", ram_wea, e_wea);
        check("ram_addra", ram_addra, e_addra);
        check("ram_dina", ram_dina, e_dina);
        check("ram_addrb", ram_addrb, e_addrb);
        if (eg0) begin
            if (w0 != 0) model_write(a0, w0, d0);
            else exp_q0.push_back('{exp_mem[a0], cyc_cnt + 1});
        end
        if (eg1) begin
            if (w1 != 0) model_write(a1, w1, d1);
            else exp_q1.push_back('{exp_mem[a1], cyc_cnt + 1});
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Held in reset: a write request must not reach the RAM.
    task automatic reset_cycle();
        @(negedge clka);
        m0_req = 1'b0; m0_we = '0;
        m1_req = 1'b1; m1_we = 4'hF; m1_addr = 12'h040; m1_wdata = 32'h1234_5678;
        #1;
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_ram_wea", ram_wea, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
    endtask

    task automatic release_reset();
        m0_req = 1'b0; m1_req = 1'b0; m0_we = '0; m1_we = '0;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            exp_mem[i] = '0;
        end
        repeat (3) reset_cycle();
        release_reset();

        // Write then read back the same word.
        step(1, 4'hF, 12'h010, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0);
        step(1, 4'h0, 12'h010, 0,             0, 0, 0, 0, 1, 0);
        idle();

        // Byte strobes: only bytes 0 and 2 change.
        step(1, 4'hF, 12'h020, 32'h1122_3344, 0, 0, 0, 0, 1, 0);
        step(1, 4'h5, 12'h020, 32'hAABB_CCDD, 0, 0, 0, 0, 1, 0);
        step(1, 4'h0, 12'h020, 0,             0, 0, 0, 0, 1, 0);
        idle();

        // Seed two words from m1 (leaves m1 as last winner).
        step(0, 0, 0, 0, 1, 4'hF, 12'h001, 32'h0000_0A01, 0, 1);
        step(0, 0, 0, 0, 1, 4'hF, 12'h002, 32'h0000_0B02, 0, 1);

        // Contention: back-to-back reads alternate m0, m1, m0, m1.
        step(1, 0, 12'h001, 0, 1, 0, 12'h002, 0, 1, 0);
        step(1, 0, 12'h001, 0, 1, 0, 12'h002, 0, 0, 1);
        step(1, 0, 12'h001, 0, 1, 0, 12'h002, 0, 1, 0);
        step(1, 0, 12'h001, 0, 1, 0, 12'h002, 0, 0, 1);
        idle();

        // Fairness survives an idle cycle; the loser keeps requesting.
        step(0, 0, 0, 0, 1, 0, 12'h020, 0, 0, 1);
        idle();
        step(1, 0, 12'h010, 0, 1, 0, 12'h001, 0, 1, 0);
        step(0, 0, 0,       0, 1, 0, 12'h001, 0, 0, 1);
        idle();

        // Write by m1 followed by a read of the same word by m0.
        step(0, 0,    0,       0, 1, 4'hF, 12'h030, 32'hCAFE_F00D, 0, 1);
        step(1, 4'h0, 12'h030, 0, 0, 0,    0,       0,             1, 0);
        idle();

        // Reset lands on the edge that would launch m0's read response.
        step(1, 4'h0, 12'h030, 0, 0, 0, 0, 0, 1, 0);
        rst = 1'b1;
        m0_req = 1'b0;
        void'(exp_q0.pop_back());
        repeat (2) reset_cycle();
        release_reset();
        idle();

        // First contention after reset goes to m0; 0x040 was never written.
        step(1, 0, 12'h040, 0, 1, 0, 12'h002, 0, 1, 0);
        step(0, 0, 0,       0, 1, 0, 12'h002, 0, 0, 1);
        repeat (3) idle();

        check("m0_queue_drained", exp_q0.size(), 0);
        check("m1_queue_drained", exp_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
